// File: rtl/irq_controller_if.sv
// Load/store bus between the CPU datapath and the interrupt controller's
// register window; the master is the CPU side, the slave is the controller.
interface irq_controller_if;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd_data;
    logic        IrqAddress;

    modport master (
        output address,
        output wr_data,
        output MemRead,
        output MemWrite,
        input  rd_data,
        input  IrqAddress
    );

    modport slave (
        input  address,
        input  wr_data,
        input  MemRead,
        input  MemWrite,
        output rd_data,
        output IrqAddress
    );
endinterface

// File: rtl/irq_controller.sv
// Edge-capturing, maskable interrupt controller with a 3-word register window
// and a single-outstanding REQ -> SERVICE -> ERET handshake toward cp0.
module irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0020
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_controller_if.slave    bus,
    output logic               irq_out,
    output logic [3:0]         irq_id,
    input  logic               taken,
    input  logic               eret
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [29:0] L_WORD_PEND = BASE_ADDR[31:2];
    localparam logic [29:0] L_WORD_MASK = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0] L_WORD_STAT = BASE_ADDR[31:2] + 30'd2;

    state_t             r_state;
    state_t             w_next_state;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [3:0]         r_id;

    logic [29:0]        w_word;
    logic               w_hit_pend;
    logic               w_hit_mask;
    logic               w_hit_stat;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_active;
    logic               w_any_active;
    logic [3:0]         w_winner;
    logic [NUM_SRC-1:0] w_win_onehot;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_take_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic               w_mask_we;
    logic               w_take;
    logic               w_in_service;
    logic [31:0]        w_status;
    logic               w_unused;

    // Address decode: byte offset bits are ignored, only the three words hit.
    assign w_word         = bus.address[31:2];
    assign w_hit_pend     = (w_word == L_WORD_PEND);
    assign w_hit_mask     = (w_word == L_WORD_MASK);
    assign w_hit_stat     = (w_word == L_WORD_STAT);
    assign bus.IrqAddress = w_hit_pend | w_hit_mask | w_hit_stat;

    assign w_unused = ^{bus.address[1:0], bus.wr_data[31:NUM_SRC]};

    assign w_edge       = irq_src & ~r_src_q;
    assign w_active     = r_pending & r_mask;
    assign w_any_active = |w_active;

    // Lowest set index wins, so scan downward and let the last hit stick.
    always_comb begin
        w_winner = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_winner = 4'(i);
            end
        end
    end

    assign w_win_onehot = NUM_SRC'(1) << w_winner;
    assign w_mask_we    = bus.MemWrite & w_hit_mask;
    assign w_w1c        = (bus.MemWrite & w_hit_pend) ? bus.wr_data[NUM_SRC-1:0] : '0;
    assign w_take_clr   = (w_take & w_any_active) ? w_win_onehot : '0;

    // A fresh edge is OR-ed in last so it survives any same-cycle clear.
    assign w_pending_nxt = (r_pending & ~w_w1c & ~w_take_clr) | w_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        irq_out      = 1'b0;
        w_in_service = 1'b0;
        irq_id       = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_active) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                irq_out = 1'b1;
                irq_id  = w_winner;
                if (taken) begin
                    w_take       = 1'b1;
                    w_next_state = ST_SERVICE;
                end else if (!w_any_active) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                w_in_service = 1'b1;
                irq_id       = r_id;
                if (eret) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_src_q   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_id      <= 4'd0;
        end else begin
            r_src_q   <= irq_src;
            r_pending <= w_pending_nxt;
            if (w_mask_we) begin
                r_mask <= bus.wr_data[NUM_SRC-1:0];
            end
            if (w_take) begin
                r_id <= w_winner;
            end
        end
    end

    assign w_status = {27'd0, w_in_service, irq_id};

    always_comb begin
        bus.rd_data = 32'd0;
        if (bus.MemRead) begin
            if (w_hit_pend) begin
                bus.rd_data = 32'(r_pending);
            end else if (w_hit_mask) begin
                bus.rd_data = 32'(r_mask);
            end else if (w_hit_stat) begin
                bus.rd_data = w_status;
            end
        end
    end

endmodule
